bus_rr_arbiter: RTL and testbench

Round-robin bus controller that shares one broadcast-capable packet bus among `drvrs` driver/monitor ports. Each port exposes a show-ahead FIFO (`pndng`, `D_pop`, `pop`). The controller picks one pending port at a time, pops one packet from it, decodes the destination ID in the packet header, and pushes the packet to the destination port (or to all other ports on broadcast). It sits between the per-port driver FIFOs and the receive FIFOs, in place of the bus generator/arbiter in the bench environment.

---
 rtl/bus_rr_arbiter.sv | 148 ++++++++++++++
 tb/tb_bus_rr_arbiter.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_rr_arbiter.sv
// bus_rr_arbiter: round-robin controller that moves one packet at a time from a
// pending driver FIFO to the receive FIFO(s) named by the packet's header ID.
// Each transfer takes IDLE (arbitrate) -> POP (consume head) -> SEND (push).
module bus_rr_arbiter #(
    parameter int         drvrs     = 4,
    parameter int         pckg_sz   = 16,
    parameter logic [7:0] broadcast = 8'hFF
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [drvrs-1:0]              pndng,
    input  logic [drvrs-1:0][pckg_sz-1:0] D_pop,
    output logic [drvrs-1:0]              pop,
    output logic [drvrs-1:0]              push,
    output logic [pckg_sz-1:0]            D_push,
    output logic [$clog2(drvrs)-1:0]      grant_id,
    output logic                          busy,
    output logic                          err_addr,
    output logic [15:0]                   pkt_cnt
);

    localparam int IW = $clog2(drvrs);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        POP  = 2'd1,
        SEND = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [IW-1:0]      last_q, last_d;
    logic [IW-1:0]      grant_q, grant_d;
    logic [drvrs-1:0]   pop_q, pop_d;
    logic [drvrs-1:0]   push_q, push_d;
    logic [pckg_sz-1:0] data_q, data_d;
    logic               err_q, err_d;
    logic [15:0]        cnt_q, cnt_d;

    logic               winFound;
    logic [IW-1:0]      winIdx;
    logic [IW-1:0]      candIdx;
    logic [7:0]         headId;
    logic [drvrs-1:0]   destMask;

    // Round-robin pick: first pending port scanning upward from last+1, wrapping.
    always_comb begin
        winFound = 1'b0;
        winIdx   = '0;
        candIdx  = '0;
        for (int k = 1; k <= drvrs; k++) begin
            candIdx = IW'((int'(last_q) + k) % drvrs);
            if (!winFound && pndng[candIdx]) begin
                winFound = 1'b1;
                winIdx   = candIdx;
            end
        end
    end

    // Destination decode of the granted port's head packet; zero mask means drop.
    always_comb begin
        headId   = D_pop[grant_q][pckg_sz-1 -: 8];
        destMask = '0;
        if (headId == broadcast) begin
            for (int j = 0; j < drvrs; j++) begin
                destMask[j] = (j != int'(grant_q));
            end
        end else if ((int'(headId) < drvrs) && (int'(headId) != int'(grant_q))) begin
            for (int j = 0; j < drvrs; j++) begin
                destMask[j] = (j == int'(headId));
            end
        end
    end

    // Next-state and registered-output logic; pop/push/err are single-cycle pulses.
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        grant_d = grant_q;
        pop_d   = '0;
        push_d  = '0;
        data_d  = data_q;
        err_d   = 1'b0;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (winFound) begin
                    state_d = POP;
                    grant_d = winIdx;
                    for (int j = 0; j < drvrs; j++) begin
                        pop_d[j] = (j == int'(winIdx));
                    end
                end
            end
            POP: begin
                if (pndng[grant_q]) begin
                    data_d  = D_pop[grant_q];
                    push_d  = destMask;
                    err_d   = (destMask == '0);
                    last_d  = grant_q;
                    state_d = SEND;
                end else begin
                    state_d = IDLE;
                end
            end
            SEND: begin
                if (push_q != '0) begin
                    cnt_d = cnt_q + 16'd1;
                end
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers; reset parks the pointer so port 0 wins first.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            last_q  <= IW'(drvrs - 1);
            grant_q <= '0;
            pop_q   <= '0;
            push_q  <= '0;
            data_q  <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            grant_q <= grant_d;
            pop_q   <= pop_d;
            push_q  <= push_d;
            data_q  <= data_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    assign pop      = pop_q;
    assign push     = push_q;
    assign D_push   = data_q;
    assign grant_id = grant_q;
    assign busy     = (state_q != IDLE);
    assign err_addr = err_q;
    assign pkt_cnt  = cnt_q;

endmodule

// File: tb/tb_bus_rr_arbiter.sv
// Testbench for bus_rr_arbiter: driver FIFOs modelled as queues, directed
// scenarios plus randomized traffic checked against a transaction-level model.
module tb_bus_rr_arbiter;

    localparam int N = 4;
    localparam int W = 16;

    logic                clk;
    logic                reset;
    logic [N-1:0]        pndng;
    logic [N-1:0][W-1:0] D_pop;
    logic [N-1:0]        pop;
    logic [N-1:0]        push;
    logic [W-1:0]        D_push;
    logic [1:0]          grant_id;
    logic                busy;
    logic                err_addr;
    logic [15:0]         pkt_cnt;

    bus_rr_arbiter #(.drvrs(N), .pckg_sz(W), .broadcast(8'hFF)) dut (
        .clk(clk), .reset(reset), .pndng(pndng), .D_pop(D_pop), .pop(pop),
        .push(push), .D_push(D_push), .grant_id(grant_id), .busy(busy),
        .err_addr(err_addr), .pkt_cnt(pkt_cnt)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [W-1:0] fifo [N][$];
    logic [N-1:0] popPrev = '0;
    int           checks = 0;
    int           failures = 0;
    int           cycles = 0;

    // Reference model: one transfer occupies three edges; expected outputs per cycle.
    int           mPhase;
    int           mLast;
    logic [N-1:0] mMask;
    logic [W-1:0] mPkt;
    logic [W-1:0] mData;
    logic [15:0]  mCnt;
    logic [N-1:0] ePop, ePush;
    logic [1:0]   eGrant;
    logic         eErr, eBusy;

    int          dPort [4] = '{2, 1, 3, 3};
    logic [15:0] dPkt  [4] = '{16'h01AB, 16'hFF55, 16'h0312, 16'h0912};
    logic [3:0]  dMask [4] = '{4'b0010, 4'b1101, 4'b0000, 4'b0000};
    logic        dErr  [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    logic [15:0] dCnt  [4] = '{16'd1, 16'd2, 16'd2, 16'd2};

    function automatic int rrPick(int last, logic [N-1:0] req);
        for (int k = 1; k <= N; k++) begin
            if (req[(last + k) % N]) return (last + k) % N;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] destOf(int src, logic [W-1:0] pkt);
        logic [N-1:0] m;
        int id;
        id = int'(pkt[W-1 -: 8]);
        m = '0;
        if (id == 255) begin
            m = '1;
            m[src] = 1'b0;
        end else if (id < N && id != src) begin
            m[id] = 1'b1;
        end
        return m;
    endfunction

    function automatic logic [W-1:0] randPkt(int src);
        int kind;
        logic [7:0] id;
        kind = $urandom_range(0, 9);
        if (kind <= 5)      id = 8'((src + 1 + $urandom_range(0, N - 2)) % N);
        else if (kind <= 7) id = 8'hFF;
        else if (kind == 8) id = 8'(src);
        else                id = 8'($urandom_range(N, 254));
        return {id, 8'($urandom_range(0, 255))};
    endfunction

    task automatic refreshInputs();
        for (int i = 0; i < N; i++) begin
            pndng[i] = (fifo[i].size() != 0);
            D_pop[i] = (fifo[i].size() != 0) ? fifo[i][0] : '0;
        end
    endtask

    task automatic modelReset();
        mPhase = 0; mLast = N - 1; mMask = '0; mPkt = '0; mData = '0; mCnt = '0;
        ePop = '0; ePush = '0; eGrant = '0; eErr = 1'b0; eBusy = 1'b0;
    endtask

    // Predicts what the upcoming rising edge does to the arbiter outputs.
    task automatic modelEdge();
        int w;
        ePop = '0; ePush = '0; eErr = 1'b0;
        if (mPhase == 1) begin
            mPhase = 2; ePush = mMask; mData = mPkt; eErr = (mMask == '0);
        end else if (mPhase == 2) begin
            mPhase = 0;
            if (mMask != '0) mCnt = mCnt + 16'd1;
        end else begin
            w = rrPick(mLast, pndng);
            if (w >= 0) begin
                mPhase = 1; mLast = w; eGrant = 2'(w); ePop[w] = 1'b1;
                mPkt = fifo[w][0]; mMask = destOf(w, mPkt);
            end
        end
        eBusy = (mPhase != 0);
    endtask

    // One clock: model the edge, let FIFOs consume popped heads, sample at negedge.
    task automatic stepCycle();
        modelEdge();
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (popPrev[i] && fifo[i].size() != 0) void'(fifo[i].pop_front());
        end
        refreshInputs();
        @(negedge clk);
        popPrev = pop;
        cycles++;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #3 reset = 1'b0;
        #1;
        checks++;
        if ({pop, push, D_push, grant_id, busy, err_addr, pkt_cnt} !== '0) begin
            failures++;
            $display("[TB] FAIL reset_async got=%h want=0", {pop, push, D_push, grant_id, busy, err_addr, pkt_cnt});
        end
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        modelReset();
        for (int c = 0; c < 20; c++) begin
            stepCycle();
            checks++;
            if ({pop, push, D_push, grant_id, busy, err_addr, pkt_cnt} !== '0) begin
                failures++;
                $display("[TB] FAIL idle_quiet cycle=%0d got=%h want=0", cycles, {pop, push, D_push, grant_id, busy, err_addr, pkt_cnt});
            end
        end
    endtask

    task automatic test_directed();
        logic [N-1:0] oh;
        for (int i = 0; i < 4; i++) begin
            oh = '0;
            oh[dPort[i]] = 1'b1;
            fifo[dPort[i]].push_back(dPkt[i]);
            refreshInputs();
            stepCycle();
            checks++;
            if (pop !== oh || grant_id !== 2'(dPort[i]) || busy !== 1'b1 || push !== '0) begin
                failures++;
                $display("[TB] FAIL dir_pop[%0d] got pop=%b grant=%0d busy=%b push=%b want pop=%b grant=%0d busy=1 push=0", i, pop, grant_id, busy, push, oh, dPort[i]);
            end
            stepCycle();
            checks++;
            if (push !== dMask[i] || D_push !== dPkt[i] || err_addr !== dErr[i] || pop !== '0) begin
                failures++;
                $display("[TB] FAIL dir_send[%0d] got push=%b data=%h err=%b pop=%b want push=%b data=%h err=%b pop=0", i, push, D_push, err_addr, pop, dMask[i], dPkt[i], dErr[i]);
            end
            stepCycle();
            checks++;
            if (pkt_cnt !== dCnt[i] || push !== '0 || err_addr !== 1'b0 || busy !== 1'b0) begin
                failures++;
                $display("[TB] FAIL dir_done[%0d] got cnt=%0d push=%b err=%b busy=%b want cnt=%0d push=0 err=0 busy=0", i, pkt_cnt, push, err_addr, busy, dCnt[i]);
            end
        end
    endtask

    task automatic test_round_robin();
        int seen;
        int lastGrant;
        seen = 0;
        lastGrant = -1;
        for (int p = 0; p < N; p++) begin
            for (int k = 0; k < 3; k++) fifo[p].push_back(randPkt(p));
        end
        refreshInputs();
        for (int c = 0; c < 60 && (seen < 12 || mPhase != 0); c++) begin
            stepCycle();
            checks++;
            if ({pop, push, D_push, err_addr, busy, pkt_cnt} !== {ePop, ePush, mData, eErr, eBusy, mCnt}) begin
                failures++;
                $display("[TB] FAIL rr_model cycle=%0d got=%h want=%h", cycles, {pop, push, D_push, err_addr, busy, pkt_cnt}, {ePop, ePush, mData, eErr, eBusy, mCnt});
            end
            checks++;
            if ((pop != '0 && push != '0) || !$onehot0(pop)) begin
                failures++;
                $display("[TB] FAIL rr_overlap cycle=%0d got pop=%b push=%b want disjoint one-hot pop", cycles, pop, push);
            end
            if (pop != '0) begin
                checks++;
                if (grant_id !== 2'(seen % N)) begin
                    failures++;
                    $display("[TB] FAIL rr_grant n=%0d got=%0d want=%0d", seen, grant_id, seen % N);
                end
                if (lastGrant >= 0) begin
                    checks++;
                    if (cycles - lastGrant != 3) begin
                        failures++;
                        $display("[TB] FAIL rr_spacing n=%0d got=%0d want=3", seen, cycles - lastGrant);
                    end
                end
                lastGrant = cycles;
                seen++;
            end
        end
        checks++;
        if (seen != 12) begin
            failures++;
            $display("[TB] FAIL rr_timeout got=%0d grants want=12", seen);
        end
    endtask

    task automatic test_random();
        int  p;
        bit  idle;
        idle = 1'b0;
        for (int c = 0; c < 600 && !idle; c++) begin
            if (c < 300 && $urandom_range(0, 2) == 0) begin
                p = $urandom_range(0, N - 1);
                fifo[p].push_back(randPkt(p));
                refreshInputs();
            end
            stepCycle();
            checks++;
            if (pop !== ePop) begin failures++; $display("[TB] FAIL rnd_pop cycle=%0d got=%b want=%b", cycles, pop, ePop); end
            checks++;
            if (push !== ePush) begin failures++; $display("[TB] FAIL rnd_push cycle=%0d got=%b want=%b", cycles, push, ePush); end
            checks++;
            if (D_push !== mData) begin failures++; $display("[TB] FAIL rnd_data cycle=%0d got=%h want=%h", cycles, D_push, mData); end
            checks++;
            if (grant_id !== eGrant) begin failures++; $display("[TB] FAIL rnd_grant cycle=%0d got=%0d want=%0d", cycles, grant_id, eGrant); end
            checks++;
            if (err_addr !== eErr) begin failures++; $display("[TB] FAIL rnd_err cycle=%0d got=%b want=%b", cycles, err_addr, eErr); end
            checks++;
            if (busy !== eBusy) begin failures++; $display("[TB] FAIL rnd_busy cycle=%0d got=%b want=%b", cycles, busy, eBusy); end
            checks++;
            if (pkt_cnt !== mCnt) begin failures++; $display("[TB] FAIL rnd_cnt cycle=%0d got=%0d want=%0d", cycles, pkt_cnt, mCnt); end
            idle = (c >= 300) && (mPhase == 0) && (pndng == '0);
        end
        checks++;
        if (!idle) begin
            failures++;
            $display("[TB] FAIL rnd_drain got pending=%b want drained", pndng);
        end
    endtask

    task automatic test_reset_mid_send();
        fifo[1].push_back(16'h0233);
        refreshInputs();
        stepCycle();
        stepCycle();
        checks++;
        if (push !== 4'b0100 || pkt_cnt === 16'd0) begin
            failures++;
            $display("[TB] FAIL midsend_setup got push=%b cnt=%0d want push=0100 cnt!=0", push, pkt_cnt);
        end
        #2 reset = 1'b0;
        #1;
        checks++;
        if ({push, D_push, pkt_cnt, busy, pop} !== '0) begin
            failures++;
            $display("[TB] FAIL midsend_clear got push=%b data=%h cnt=%0d busy=%b pop=%b want all 0", push, D_push, pkt_cnt, busy, pop);
        end
        @(negedge clk);
        reset = 1'b1;
        for (int p = 0; p < N; p++) fifo[p].delete();
        popPrev = '0;
        modelReset();
        for (int p = 0; p < N; p++) fifo[p].push_back(randPkt(p));
        refreshInputs();
        stepCycle();
        checks++;
        if (pop !== 4'b0001 || grant_id !== 2'd0) begin
            failures++;
            $display("[TB] FAIL first_grant got pop=%b grant=%0d want pop=0001 grant=0", pop, grant_id);
        end
        for (int c = 0; c < 12; c++) begin
            stepCycle();
            checks++;
            if (pop !== ePop || push !== ePush || D_push !== mData || pkt_cnt !== mCnt) begin
                failures++;
                $display("[TB] FAIL post_reset cycle=%0d got pop=%b push=%b data=%h cnt=%0d want pop=%b push=%b data=%h cnt=%0d", cycles, pop, push, D_push, pkt_cnt, ePop, ePush, mData, mCnt);
            end
        end
    endtask

    // Safety net in case the sequence below ever stalls.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog expired got=timeout want=finish");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        pndng = '0;
        D_pop = '0;
        modelReset();
        test_reset();
        test_directed();
        test_round_robin();
        test_random();
        test_reset_mid_send();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
